// File: rtl/pixel_coord_accum.sv
// Per-pixel homogeneous coordinate accumulator.
//
// Walks a frame of H_PIXELS x V_LINES in raster order and emits a word per pixel:
//   num_x = p1*x + p2*y + p3, num_y = p4*x + p5*y + p6, denom = p7*x + p8*y + p9
// It uses incremental adds only. Steps and row-rewind values are captured on start.
// The origin values are captured by loading them straight into the accumulators.
// Words are offered with a valid/ready handshake to a downstream divider.
//
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   start                 frame-start request, honoured only while idle
//   p1..p9_inv            step / origin coefficients (signed)
//   dec_num*_horiz,
//   dec_denom_horiz       row rewind values, step*(H_PIXELS-1), supplied precomputed
//   out_valid, out_ready  output handshake
//   num_x, num_y, denom   accumulated values for pixel (x_out, y_out)
//   last                  current word is the final pixel of the frame
//   busy                  frame in progress
//   frame_done            one-cycle pulse after the final pixel is accepted
module pixel_coord_accum #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [67:0] p1_inv,
  input  logic signed [68:0] p2_inv,
  input  logic signed [78:0] p3_inv,
  input  logic signed [67:0] p4_inv,
  input  logic signed [68:0] p5_inv,
  input  logic signed [78:0] p6_inv,
  input  logic signed [58:0] p7_inv,
  input  logic signed [59:0] p8_inv,
  input  logic signed [70:0] p9_inv,
  input  logic signed [78:0] dec_numx_horiz,
  input  logic signed [78:0] dec_numy_horiz,
  input  logic signed [70:0] dec_denom_horiz,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [78:0] num_x,
  output logic signed [78:0] num_y,
  output logic signed [70:0] denom,
  output logic [9:0]         x_out,
  output logic [8:0]         y_out,
  output logic               last,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [9:0] XLast = 10'(H_PIXELS - 1);
  localparam logic [8:0] YLast = 9'(V_LINES - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e state_q, state_d;

  // Captured coefficients, already sign-extended to accumulator width.
  logic signed [78:0] step_hx_q, step_hy_q, step_vx_q, step_vy_q, rew_x_q, rew_y_q;
  logic signed [70:0] step_hd_q, step_vd_q, rew_d_q;

  logic signed [78:0] num_x_q, num_y_q;
  logic signed [70:0] denom_q;
  logic [9:0]         x_q;
  logic [8:0]         y_q;
  logic               frame_done_q, frame_done_d;

  logic load, xfer, at_x_end, at_last;

  assign at_x_end = (x_q == XLast);
  assign at_last  = at_x_end && (y_q == YLast);

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    xfer         = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // start is deliberately not looked at here, even on the final transfer.
        if (out_ready) begin
          xfer = 1'b1;
          if (at_last) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      frame_done_q <= 1'b0;
      step_hx_q    <= '0;
      step_hy_q    <= '0;
      step_vx_q    <= '0;
      step_vy_q    <= '0;
      rew_x_q      <= '0;
      rew_y_q      <= '0;
      step_hd_q    <= '0;
      step_vd_q    <= '0;
      rew_d_q      <= '0;
      num_x_q      <= '0;
      num_y_q      <= '0;
      denom_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      if (load) begin
        step_hx_q <= {{11{p1_inv[67]}}, p1_inv};
        step_hy_q <= {{11{p4_inv[67]}}, p4_inv};
        step_vx_q <= {{10{p2_inv[68]}}, p2_inv};
        step_vy_q <= {{10{p5_inv[68]}}, p5_inv};
        step_hd_q <= {{12{p7_inv[58]}}, p7_inv};
        step_vd_q <= {{11{p8_inv[59]}}, p8_inv};
        rew_x_q   <= dec_numx_horiz;
        rew_y_q   <= dec_numy_horiz;
        rew_d_q   <= dec_denom_horiz;
        num_x_q   <= p3_inv;
        num_y_q   <= p6_inv;
        denom_q   <= p9_inv;
        x_q       <= '0;
        y_q       <= '0;
      end else if (xfer && !at_last) begin
        if (!at_x_end) begin
          num_x_q <= num_x_q + step_hx_q;
          num_y_q <= num_y_q + step_hy_q;
          denom_q <= denom_q + step_hd_q;
          x_q     <= x_q + 10'd1;
        end else begin
          // Rewind to column 0 of the current row, then step down one row.
          num_x_q <= num_x_q - rew_x_q + step_vx_q;
          num_y_q <= num_y_q - rew_y_q + step_vy_q;
          denom_q <= denom_q - rew_d_q + step_vd_q;
          x_q     <= '0;
          y_q     <= y_q + 9'd1;
        end
      end
    end
  end

  assign out_valid  = (state_q == StRun);
  assign busy       = (state_q == StRun);
  assign last       = out_valid && at_last;
  assign frame_done = frame_done_q;
  assign num_x      = num_x_q;
  assign num_y      = num_y_q;
  assign denom      = denom_q;
  assign x_out      = x_q;
  assign y_out      = y_q;

endmodule

// File: doc/pixel_coord_accum.md
PIXEL_COORD_ACCUM -- requirements
Module: pixel_coord_accum

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, output frame width in pixels.
REQ-002 SHALL have parameter V_LINES, default 480, output frame height in lines.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle frame-start request.
- p1_inv, p4_inv  in  68 each, signed  horizontal step, X and Y numerators.
- p2_inv, p5_inv  in  69 each, signed  vertical step, X and Y numerators.
- p3_inv, p6_inv  in  79 each, signed  origin value, X and Y numerators.
- p7_inv  in  59, signed  horizontal step, denominator.
- p8_inv  in  60, signed  vertical step, denominator.
- p9_inv  in  71, signed  origin value, denominator.
- dec_numx_horiz, dec_numy_horiz  in  79 each, signed  row rewind values, numerators.
- dec_denom_horiz  in  71, signed  row rewind value, denominator.
- out_valid  out  1  pixel word valid.
- out_ready  in  1  downstream divider accepts word.
- num_x, num_y  out  79 each, signed  p1_inv*x + p2_inv*y + p3_inv, and p4_inv*x + p5_inv*y + p6_inv.
- denom  out  71, signed  p7_inv*x + p8_inv*y + p9_inv.
- x_out  out  10  current pixel column.
- y_out  out  9  current pixel row.
- last  out  1  current word is pixel (H_PIXELS-1, V_LINES-1).
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-004 SHALL implement states IDLE and RUN.
REQ-005 In IDLE with start=1, SHALL latch all twelve parameter inputs and enter RUN.
- On the same edge: num_x=p3_inv, num_y=p6_inv, denom=p9_inv, x_out=0, y_out=0.
- out_valid=1 and busy=1 on the following cycle (latency 1).
REQ-006 SHALL ignore parameter inputs at all other times; parameters upstream may change mid-frame without effect.
REQ-007 SHALL ignore start while in RUN, including on the cycle the last pixel is accepted.
REQ-008 A transfer occurs on a clock edge where out_valid=1 and out_ready=1.
REQ-009 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-010 On a transfer with x_out<H_PIXELS-1, SHALL add latched p1_inv, p4_inv and p7_inv to num_x, num_y and denom, and increment x_out.
REQ-011 On a transfer with x_out=H_PIXELS-1 and y_out<V_LINES-1, SHALL:
- set num_x to num_x - dec_numx_horiz + p2_inv;
- set num_y to num_y - dec_numy_horiz + p5_inv;
- set denom to denom - dec_denom_horiz + p8_inv;
- set x_out=0 and increment y_out.
REQ-012 All addends SHALL be sign-extended to the accumulator width; accumulators wrap modulo 2^79 (numerators) and 2^71 (denominator); no saturation.
REQ-013 dec_* inputs are defined as step*(H_PIXELS-1); the block SHALL NOT recompute them.
REQ-014 last SHALL equal out_valid AND x_out=H_PIXELS-1 AND y_out=V_LINES-1.
REQ-015 On the transfer of the last pixel, SHALL go to IDLE with out_valid=0 and busy=0 next cycle, and pulse frame_done for exactly that one cycle.
REQ-016 out_valid SHALL never be 1 in IDLE; frame_done SHALL never be 1 in RUN.
REQ-017 Accumulation SHALL be exact: every output word equals the closed-form value of REQ-003 modulo accumulator width.

Reset
REQ-018 With reset_n=0 at a clock edge, SHALL enter IDLE and clear all of: out_valid, busy, last, frame_done, x_out, y_out, num_x, num_y, denom and latched parameters.
REQ-019 Reset SHALL take priority over start and over any transfer.
REQ-020 Reset mid-frame SHALL abort the frame with no frame_done pulse.
REQ-021 After reset, a new start SHALL behave per REQ-005.

Verification
REQ-022 Identity parameters: p1=p5=p9=1, others 0, dec_numx=639, dec_numy=dec_denom=0, out_ready=1 -> 307200 words with num_x=x, num_y=y, denom=1; frame_done pulses one cycle after (639,479).
REQ-023 Row wrap, p1=3, p2=-7, p3=100, dec_numx=1917 -> word (639,0) has num_x=2017, word (0,1) has num_x=93.
REQ-024 Random out_ready toggling -> outputs stable while stalled; no duplicates or skips; words match the closed form.
REQ-025 start pulsed at pixel (10,5), with changed parameter inputs -> frame continues unchanged with the original parameters.
REQ-026 reset_n=0 at pixel (300,200) -> next cycle out_valid=0, busy=0, no frame_done; a subsequent start begins again at (0,0).
REQ-027 Negative steps: p7=-1, p9=5, dec_denom=-639 -> denom=5-x for each pixel; two's-complement correct across the negative values.
